// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the serial stages (piso serializer, sipo deserializer).
// Holds the serial-stage state encoding, bit-order constants and a counter-width helper.
package piso_serializer_pkg;

  // Serial stage control states
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  // Bit-order selectors used for the MSB_FIRST parameter
  localparam bit BIT_ORDER_MSB_FIRST = 1'b1;
  localparam bit BIT_ORDER_LSB_FIRST = 1'b0;

  // Width of a bit counter spanning 0..width-1; never narrower than one bit
  function automatic int cnt_width(input int width);
    if (width <= 2) begin
      return 1;
    end
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage feeding the sipo deserializer.
// Words arrive over valid/ready and leave one bit per clock. A one-entry
// holding register lets the next word queue up behind the word being shifted,
// so consecutive words stream with no idle bit between them.
//
// state | meaning
// IDLE  | no word in flight, serial outputs quiet, waiting for a transfer
// SHIFT | shift_reg drives one bit per cycle, bit_cnt = index of that bit
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] par_data_in,
  input  logic             par_valid,
  output logic             par_ready,
  output logic             serial_data_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             last_bit
);

  import piso_serializer_pkg::*;

  localparam int                CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);
  localparam bit                MSB_MODE = (MSB_FIRST == BIT_ORDER_MSB_FIRST);

  ser_state_e       state;
  ser_state_e       state_next;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic [WIDTH-1:0] shift_step;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             hold_full;
  logic             hold_full_next;
  logic [WIDTH-1:0] hold_reg;
  logic [WIDTH-1:0] hold_next;
  logic             xfer;
  logic             on_last;
  logic             out_bit;

  // Ready depends only on the holding register, never on par_valid
  assign par_ready = !hold_full;
  assign xfer      = par_valid && par_ready;
  assign on_last   = (state == SHIFT) && (bit_cnt == LAST_CNT);

  // One-position zero-filled shift toward the outgoing end
  assign shift_step = MSB_MODE ? {shift_reg[WIDTH-2:0], 1'b0}
                               : {1'b0, shift_reg[WIDTH-1:1]};
  assign out_bit    = MSB_MODE ? shift_reg[WIDTH-1] : shift_reg[0];

  // Serial outputs decode straight from registered state so they clear with reset
  assign serial_valid    = (state == SHIFT);
  assign serial_data_out = (state == SHIFT) && out_bit;
  assign frame_start     = (state == SHIFT) && (bit_cnt == '0);
  assign last_bit        = on_last;

  // State, shift, counter and holding registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      hold_full <= 1'b0;
      hold_reg  <= '0;
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      bit_cnt   <= cnt_next;
      hold_full <= hold_full_next;
      hold_reg  <= hold_next;
    end
  end

  // Next-state logic: load, shift, queue into hold, and reload on the last bit
  always_comb begin
    state_next     = state;
    shift_next     = shift_reg;
    cnt_next       = bit_cnt;
    hold_full_next = hold_full;
    hold_next      = hold_reg;

    case (state)
      IDLE: begin
        if (xfer) begin
          shift_next = par_data_in;
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end

      SHIFT: begin
        if (bit_cnt == LAST_CNT) begin
          // Held word wins over a fresh transfer; ready is low when hold is full anyway
          if (hold_full) begin
            shift_next     = hold_reg;
            hold_full_next = 1'b0;
            cnt_next       = '0;
          end else if (xfer) begin
            shift_next = par_data_in;
            cnt_next   = '0;
          end else begin
            shift_next = shift_step;
            cnt_next   = '0;
            state_next = IDLE;
          end
        end else begin
          shift_next = shift_step;
          cnt_next   = bit_cnt + CNT_W'(1);
          if (xfer) begin
            hold_next      = par_data_in;
            hold_full_next = 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: an MSB-first and an LSB-first instance
// share one source; a small sipo model on each output checks loopback words.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] par_data_in = 4'h0;
  logic       par_valid = 1'b0;

  logic rdy_m, sdo_m, sv_m, fs_m, lb_m;
  logic rdy_l, sdo_l, sv_l, fs_l, lb_l;

  int    n_checks = 0;
  int    n_errors = 0;
  int    row = 0;
  string cur_test = "init";

  logic [3:0] q_m;
  logic [3:0] q_l;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .par_data_in(par_data_in), .par_valid(par_valid),
    .par_ready(rdy_m), .serial_data_out(sdo_m), .serial_valid(sv_m),
    .frame_start(fs_m), .last_bit(lb_m)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .par_data_in(par_data_in), .par_valid(par_valid),
    .par_ready(rdy_l), .serial_data_out(sdo_l), .serial_valid(sv_l),
    .frame_start(fs_l), .last_bit(lb_l)
  );

  // Reference sipo: MSB-first shifts in at the bottom, LSB-first at the top
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_m <= 4'h0;
      q_l <= 4'h0;
    end else begin
      if (sv_m) q_m <= {q_m[2:0], sdo_m};
      if (sv_l) q_l <= {sdo_l, q_l[3:1]};
    end
  end

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_test(input string name);
    cur_test = name;
    row = 0;
  endtask

  // Drive one cycle of input, check {valid,data,frame_start,last_bit,ready} of both instances, advance
  task automatic run_row(input logic v, input logic [3:0] d,
                         input logic [4:0] em, input logic [4:0] el);
    par_valid   = v;
    par_data_in = d;
    chk($sformatf("%s_r%0d_msb", cur_test, row), {sv_m, sdo_m, fs_m, lb_m, rdy_m}, em);
    chk($sformatf("%s_r%0d_lsb", cur_test, row), {sv_l, sdo_l, fs_l, lb_l, rdy_l}, el);
    row++;
    tick();
  endtask

  initial begin
    // Reset with a word presented; it must be dropped
    par_valid   = 1'b1;
    par_data_in = 4'hF;
    #2;
    chk("reset_msb", {sv_m, sdo_m, fs_m, lb_m, rdy_m}, 5'b00001);
    chk("reset_lsb", {sv_l, sdo_l, fs_l, lb_l, rdy_l}, 5'b00001);
    @(posedge clk);
    @(posedge clk);
    #2;
    par_valid = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();

    start_test("idle");
    run_row(1'b0, 4'h0, 5'b00001, 5'b00001);
    run_row(1'b0, 4'h0, 5'b00001, 5'b00001);

    // Single word 1011
    start_test("single");
    run_row(1'b1, 4'b1011, 5'b00001, 5'b00001);
    run_row(1'b0, 4'b0000, 5'b11101, 5'b11101);
    run_row(1'b0, 4'b0000, 5'b10001, 5'b11001);
    run_row(1'b0, 4'b0000, 5'b11001, 5'b10001);
    run_row(1'b0, 4'b0000, 5'b11011, 5'b11011);
    chk("loop_single_msb", {1'b0, q_m}, 5'b01011);
    chk("loop_single_lsb", {1'b0, q_l}, 5'b01011);
    run_row(1'b0, 4'b0000, 5'b00001, 5'b00001);

    // Back-to-back 1011 then 0110, second word goes through hold
    start_test("b2b");
    run_row(1'b1, 4'b1011, 5'b00001, 5'b00001);
    run_row(1'b1, 4'b0110, 5'b11101, 5'b11101);
    run_row(1'b0, 4'b0000, 5'b10000, 5'b11000);
    run_row(1'b0, 4'b0000, 5'b11000, 5'b10000);
    run_row(1'b0, 4'b0000, 5'b11010, 5'b11010);
    run_row(1'b0, 4'b0000, 5'b10101, 5'b10101);
    run_row(1'b0, 4'b0000, 5'b11001, 5'b11001);
    run_row(1'b0, 4'b0000, 5'b11001, 5'b11001);
    run_row(1'b0, 4'b0000, 5'b10011, 5'b10011);
    run_row(1'b0, 4'b0000, 5'b00001, 5'b00001);

    // Hold full: 1011, 0110 accepted on bit 2, 1001 stalled until hold drains
    start_test("hold");
    run_row(1'b1, 4'b1011, 5'b00001, 5'b00001);
    run_row(1'b0, 4'b0000, 5'b11101, 5'b11101);
    run_row(1'b1, 4'b0110, 5'b10001, 5'b11001);
    run_row(1'b1, 4'b1001, 5'b11000, 5'b10000);
    run_row(1'b1, 4'b1001, 5'b11010, 5'b11010);
    run_row(1'b1, 4'b1001, 5'b10101, 5'b10101);
    run_row(1'b0, 4'b0000, 5'b11000, 5'b11000);
    run_row(1'b0, 4'b0000, 5'b11000, 5'b11000);
    run_row(1'b0, 4'b0000, 5'b10010, 5'b10010);
    run_row(1'b0, 4'b0000, 5'b11101, 5'b11101);
    run_row(1'b0, 4'b0000, 5'b10001, 5'b10001);
    run_row(1'b0, 4'b0000, 5'b10001, 5'b10001);
    run_row(1'b0, 4'b0000, 5'b11011, 5'b11011);
    chk("loop_hold_msb", {1'b0, q_m}, 5'b01001);
    chk("loop_hold_lsb", {1'b0, q_l}, 5'b01001);
    run_row(1'b0, 4'b0000, 5'b00001, 5'b00001);

    // Direct reload: next word arrives exactly on the last bit with hold empty
    start_test("direct");
    run_row(1'b1, 4'b0101, 5'b00001, 5'b00001);
    run_row(1'b0, 4'b0000, 5'b10101, 5'b11101);
    run_row(1'b0, 4'b0000, 5'b11001, 5'b10001);
    run_row(1'b0, 4'b0000, 5'b10001, 5'b11001);
    run_row(1'b1, 4'b1100, 5'b11011, 5'b10011);
    run_row(1'b0, 4'b0000, 5'b11101, 5'b10101);
    run_row(1'b0, 4'b0000, 5'b11001, 5'b10001);
    run_row(1'b0, 4'b0000, 5'b10001, 5'b11001);
    run_row(1'b0, 4'b0000, 5'b10011, 5'b11011);
    chk("loop_direct_msb", {1'b0, q_m}, 5'b01100);
    chk("loop_direct_lsb", {1'b0, q_l}, 5'b01100);
    run_row(1'b0, 4'b0000, 5'b00001, 5'b00001);

    // Reset mid-word with a word held
    start_test("rst_mid");
    run_row(1'b1, 4'b1011, 5'b00001, 5'b00001);
    run_row(1'b1, 4'b0110, 5'b11101, 5'b11101);
    par_valid = 1'b0;
    chk("rst_mid_bit2_msb", {sv_m, sdo_m, fs_m, lb_m, rdy_m}, 5'b10000);
    chk("rst_mid_bit2_lsb", {sv_l, sdo_l, fs_l, lb_l, rdy_l}, 5'b11000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_msb", {sv_m, sdo_m, fs_m, lb_m, rdy_m}, 5'b00001);
    chk("rst_async_lsb", {sv_l, sdo_l, fs_l, lb_l, rdy_l}, 5'b00001);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    start_test("post_rst");
    for (int i = 0; i < 5; i++) begin
      run_row(1'b0, 4'b0000, 5'b00001, 5'b00001);
    end
    run_row(1'b1, 4'b0001, 5'b00001, 5'b00001);
    run_row(1'b0, 4'b0000, 5'b10101, 5'b11101);
    run_row(1'b0, 4'b0000, 5'b10001, 5'b10001);
    run_row(1'b0, 4'b0000, 5'b10001, 5'b10001);
    run_row(1'b0, 4'b0000, 5'b11011, 5'b10011);
    chk("loop_post_rst_msb", {1'b0, q_m}, 5'b00001);
    chk("loop_post_rst_lsb", {1'b0, q_l}, 5'b00001);
    run_row(1'b0, 4'b0000, 5'b00001, 5'b00001);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
